// File: rtl/inc_rr_arbiter_pkg.sv
// inc_rr_arbiter_pkg: default sizes, ID width derivation and one-hot helper for the round-robin incrementer arbiter
package inc_rr_arbiter_pkg;
  localparam int DATAWIDTH_DEF = 8;
  localparam int NUM_REQ_DEF = 4;
  function automatic int id_width(input int n);
    int r;
    r = 1;
    for (int i = 1; i <= 5; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
  function automatic logic [15:0] onehot(input logic [3:0] idx);
    return 16'd1 << idx;
  endfunction
endpackage

// File: rtl/inc_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick; eff/ptr in, any/w out (rotate by ptr, lowest-set encode, rotate back)
module rr_pick
  import inc_rr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ID_W = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eff,
  input  logic [ID_W-1:0]    ptr,
  output logic               any,
  output logic [ID_W-1:0]    w
);
  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0] rot;
  logic [ID_W-1:0] idx;
  logic [ID_W:0] sum;
  assign any = |eff;
  always_comb begin
    dbl = {eff, eff} >> ptr;
    rot = dbl[NUM_REQ-1:0];
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) if (rot[i]) idx = ID_W'(i);
    sum = {1'b0, ptr} + {1'b0, idx};
    w = (sum >= (ID_W+1)'(NUM_REQ)) ? ID_W'(sum - (ID_W+1)'(NUM_REQ)) : sum[ID_W-1:0];
  end
endmodule

// File: rtl/inc_rr_arbiter.sv
// inc_rr_arbiter: shares one external incrementer (inc_a/inc_d) among req/req_data requesters; gnt pulse, tagged rsp_* two edges later
module inc_rr_arbiter
  import inc_rr_arbiter_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEF,
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ID_W = id_width(NUM_REQ)
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*DATAWIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [DATAWIDTH-1:0]         inc_a,
  input  logic [DATAWIDTH-1:0]         inc_d,
  output logic                         rsp_valid,
  output logic [ID_W-1:0]              rsp_id,
  output logic [DATAWIDTH-1:0]         rsp_data,
  output logic                         rsp_wrap
);
  logic [NUM_REQ-1:0] eff;
  logic [DATAWIDTH-1:0] op_reg;
  logic [ID_W-1:0] id_reg, ptr, w;
  logic s1_valid, any;
  logic [15:0] oh;
  assign eff = req & ~gnt;
  assign oh = onehot(4'(w));
  assign inc_a = op_reg;
  rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .eff(eff),
    .ptr(ptr),
    .any(any),
    .w(w)
  );
  always_ff @(posedge Clk) begin
    if (Rst) begin
      gnt <= '0;
      op_reg <= '0;
      id_reg <= '0;
      s1_valid <= 1'b0;
      ptr <= '0;
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_data <= '0;
      rsp_wrap <= 1'b0;
    end else begin
      gnt <= any ? oh[NUM_REQ-1:0] : '0;
      s1_valid <= any;
      if (any) begin
        op_reg <= req_data[int'(w)*DATAWIDTH +: DATAWIDTH];
        id_reg <= w;
        ptr <= (w == ID_W'(NUM_REQ - 1)) ? '0 : w + 1'b1;
      end
      rsp_valid <= s1_valid;
      if (s1_valid) begin
        rsp_id <= id_reg;
        rsp_data <= inc_d;
        rsp_wrap <= &op_reg;
      end
    end
  end
endmodule

// File: tb/tb_inc_rr_arbiter.sv
// tb_inc_rr_arbiter: directed self-checking bench for inc_rr_arbiter with a behavioural shared incrementer
module tb_inc_rr_arbiter;
  logic Clk = 1'b0;
  logic Rst;
  logic [3:0] req;
  logic [7:0] d [4];
  logic [31:0] req_data;
  logic [3:0] gnt;
  logic [7:0] inc_a, inc_d, rsp_data;
  logic rsp_valid, rsp_wrap;
  logic [1:0] rsp_id;
  int vecs = 0;
  int errs = 0;
  logic [7:0] rr_exp [4];

  assign req_data = {d[3], d[2], d[1], d[0]};
  assign inc_d = inc_a + 8'd1;

  always #5 Clk = ~Clk;

  inc_rr_arbiter dut (
    .Clk(Clk),
    .Rst(Rst),
    .req(req),
    .req_data(req_data),
    .gnt(gnt),
    .inc_a(inc_a),
    .inc_d(inc_d),
    .rsp_valid(rsp_valid),
    .rsp_id(rsp_id),
    .rsp_data(rsp_data),
    .rsp_wrap(rsp_wrap)
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rsp(input string tag, input logic [1:0] id, input logic [7:0] data, input logic wrap);
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_id"}, 32'(rsp_id), 32'(id));
    chk({tag, "_data"}, 32'(rsp_data), 32'(data));
    chk({tag, "_wrap"}, 32'(rsp_wrap), 32'(wrap));
  endtask

  initial begin
    Rst = 1'b1;
    req = 4'b1111;
    d[0] = 8'h10; d[1] = 8'h20; d[2] = 8'h41; d[3] = 8'h30;
    rr_exp[0] = 8'h11; rr_exp[1] = 8'h21; rr_exp[2] = 8'h42; rr_exp[3] = 8'h31;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_valid", 32'(rsp_valid), 32'd0);
      chk("rst_data", 32'(rsp_data), 32'd0);
    end
    chk("rst_inc_a", 32'(inc_a), 32'd0);
    Rst = 1'b0;
    step();
    chk("post_rst_gnt", 32'(gnt), 32'b0001);
    req = 4'b0000;
    step();
    chk("post_rst_gnt_drop", 32'(gnt), 32'd0);
    chk_rsp("post_rst_rsp", 2'd0, 8'h11, 1'b0);
    req = 4'b0100;
    step();
    chk("single_gnt", 32'(gnt), 32'b0100);
    chk("single_inc_a", 32'(inc_a), 32'h41);
    req = 4'b0000;
    d[2] = 8'h99;
    step();
    chk_rsp("single_rsp", 2'd2, 8'h42, 1'b0);
    chk("single_gnt_drop", 32'(gnt), 32'd0);
    d[2] = 8'h41;
    step();
    chk("single_valid_drop", 32'(rsp_valid), 32'd0);
    chk("hold_data", 32'(rsp_data), 32'h42);
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    req = 4'b1111;
    for (int n = 0; n < 6; n++) begin
      step();
      if (n < 5) chk("rr_gnt", 32'(gnt), 32'd1 << (n % 4));
      if (n >= 1) chk_rsp("rr_rsp", 2'((n - 1) % 4), rr_exp[(n - 1) % 4], 1'b0);
    end
    req = 4'b0000;
    step();
    step();
    d[1] = 8'hFF;
    req = 4'b0010;
    step();
    chk("wrap_gnt", 32'(gnt), 32'b0010);
    req = 4'b0000;
    step();
    chk_rsp("wrap_rsp", 2'd1, 8'h00, 1'b1);
    req = 4'b1000;
    for (int n = 0; n < 4; n++) begin
      step();
      chk("mask_gnt", 32'(gnt), (n % 2 == 0) ? 32'b1000 : 32'd0);
      chk("mask_valid", 32'(rsp_valid), (n % 2 == 0) ? 32'd0 : 32'd1);
    end
    req = 4'b0000;
    step();
    step();
    req = 4'b0010;
    step();
    chk("mid_gnt", 32'(gnt), 32'b0010);
    Rst = 1'b1;
    req = 4'b0000;
    step();
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    chk("mid_rst_data", 32'(rsp_data), 32'd0);
    Rst = 1'b0;
    req = 4'b0011;
    step();
    chk("mid_after_gnt", 32'(gnt), 32'b0001);
    req = 4'b0000;
    step();
    chk_rsp("mid_after_rsp", 2'd0, 8'h11, 1'b0);
    req = 4'b0100;
    step();
    chk("ptr_gnt", 32'(gnt), 32'b0100);
    Rst = 1'b1;
    req = 4'b0000;
    step();
    chk("ptr_rst_valid", 32'(rsp_valid), 32'd0);
    Rst = 1'b0;
    req = 4'b1010;
    step();
    chk("ptr_reset_gnt", 32'(gnt), 32'b0010);
    req = 4'b0000;
    step();
    chk_rsp("ptr_reset_rsp", 2'd1, 8'h00, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
